// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type and default geometry for the data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_LATENCY = 2;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port DEPTH x 32 storage with synchronous write and synchronous read.
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind a valid/ready request/response handshake.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rsp_valid_q;
    logic        err_q;
    logic        load_q;
    logic        accept;
    logic        enter_resp;
    logic        cur_we;
    logic        cur_err;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [31:0] arr_rdata;
    // With LATENCY=1 the access happens on the accept edge, so it must use the live inputs.
    always_comb begin
        accept     = state_q == IDLE && req_valid;
        cur_we     = state_q == IDLE ? req_we : we_q;
        cur_addr   = state_q == IDLE ? req_addr : addr_q;
        cur_wdata  = state_q == IDLE ? req_wdata : wdata_q;
        cur_err    = cur_addr[1:0] != 2'b00 || {2'b00, cur_addr[31:2]} >= 32'(DEPTH);
        enter_resp = !rst && ((accept && LATENCY == 1) || (state_q == WAIT && cnt_q == 4'd0));
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            load_q      <= 1'b0;
        end else if (enter_resp) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            err_q       <= cur_err;
            load_q      <= !cur_we && !cur_err;
        end else if (accept) begin
            state_q <= WAIT;
            cnt_q   <= 4'(LATENCY - 2);
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q - 4'd1;
        end else if (state_q == RESP && rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            load_q      <= 1'b0;
        end
    end
    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk     (clk),
        .we_i    (enter_resp && cur_we && !cur_err),
        .re_i    (enter_resp && !cur_we && !cur_err),
        .addr_i  (cur_addr[AW+1:2]),
        .wdata_i (cur_wdata),
        .rdata_o (arr_rdata)
    );
    assign req_ready = state_q == IDLE;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = err_q;
    assign rsp_rdata = load_q ? arr_rdata : '0;
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request accept to response valid; legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1: initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1: responder can accept a request.
REQ-007 SHALL have port req_we, input, 1: 1 = store word, 0 = load word.
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data.
REQ-010 SHALL have port rsp_valid, output, 1: response present.
REQ-011 SHALL have port rsp_ready, input, 1: initiator consumes response.
REQ-012 SHALL have port rsp_rdata, output, 32: load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err, output, 1: misaligned or out-of-range access.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL drive req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on an edge where req_valid && req_ready, latching req_we, req_addr and req_wdata; later input changes have no effect.
REQ-017 SHALL, for a request accepted at edge N, assert rsp_valid from the cycle after edge N+LATENCY-1. LATENCY=1 goes IDLE->RESP directly; otherwise IDLE->WAIT with a down-counter loaded with LATENCY-2, and WAIT->RESP when the counter is 0.
REQ-018 SHALL compute word index = addr[31:2] and flag an error when addr[1:0] != 0 or index >= DEPTH.
REQ-019 SHALL, for a valid store, write wdata to mem[index] on the edge entering RESP; rsp_rdata = 0, rsp_err = 0.
REQ-020 SHALL, for a valid load, capture mem[index] into rsp_rdata on the edge entering RESP; rsp_err = 0.
REQ-021 SHALL, on an error, perform no write and set rsp_rdata = 0, rsp_err = 1.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1.
REQ-023 SHALL return RESP->IDLE on an edge with rsp_ready = 1, clearing rsp_valid, rsp_rdata and rsp_err; no request is accepted on that same edge (minimum 1 idle cycle between transactions).
REQ-024 SHALL ignore rsp_ready outside RESP and req_valid outside IDLE.
REQ-025 SHALL make a load following a store to the same address return the stored value.

Reset
REQ-026 SHALL, with rst = 1 on an edge, set state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0; req_ready is 1 on the first cycle after reset.
REQ-027 SHALL discard an in-flight store on reset mid-WAIT; no memory write occurs.
REQ-028 SHALL NOT clear memory contents on reset.
REQ-029 SHALL give rst priority over every other event on the same edge.

Structure
REQ-030 SHALL place the state enum (IDLE/WAIT/RESP) and default DEPTH/LATENCY constants in shared package dmem_pkg.
REQ-031 SHALL isolate storage in sub-module dmem_array: synchronous write, synchronous read, single port, DEPTH x 32.

Verification
REQ-032 Reset, LATENCY=2: store 0x0000_0010 <- 0xDEAD_BEEF, then load 0x10 -> rsp_valid 2 cycles after each accept, load rsp_rdata = 0xDEAD_BEEF, rsp_err = 0.
REQ-033 Backpressure: hold rsp_ready = 0 for 5 cycles -> rsp_valid/rsp_rdata stable and req_ready = 0 throughout; accept completes 1 cycle after rsp_ready = 1.
REQ-034 Misaligned load at 0x0000_0003, and store at 0x0000_0400 with DEPTH=256 -> rsp_err = 1, rsp_rdata = 0; memory unchanged on reread.
REQ-035 LATENCY=1: back-to-back requests with rsp_ready tied 1 -> one response every 2 cycles; req_ready toggles 1,0.
REQ-036 Reset asserted in WAIT of store 0x20 <- 0x1234_5678 -> no rsp_valid, req_ready = 1 next cycle; a subsequent load of 0x20 returns its pre-store value.
REQ-037 Changing req_addr/req_wdata after accept -> response reflects the latched values only.
